// File: rtl/obi_mem_arbiter.sv
// Purpose: N-port OBI request arbiter (fixed or round-robin) in front of one single-port RAM, with address window check.
// Latency: grant is combinational in the request cycle; the response appears RD_LATENCY+1 cycles after the grant.
// Backpressure: none; every cycle with a request grants exactly one port, and masters hold their request until granted.
module obi_mem_arbiter #(
    parameter int                NUM_PORTS  = 2,
    parameter int                ADDR_W     = 32,
    parameter int                DATA_W     = 32,
    parameter int                MEM_SIZE   = 65536,
    parameter logic [ADDR_W-1:0] MEM_START  = '0,
    parameter int                ARB_MODE   = 0,
    parameter int                RD_LATENCY = 1
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [NUM_PORTS-1:0]          req_i,
    output logic [NUM_PORTS-1:0]          gnt_o,
    input  logic [NUM_PORTS-1:0]          we_i,
    input  logic [NUM_PORTS*DATA_W/8-1:0] be_i,
    input  logic [NUM_PORTS*ADDR_W-1:0]   addr_i,
    input  logic [NUM_PORTS*DATA_W-1:0]   wdata_i,
    output logic [NUM_PORTS-1:0]          rvalid_o,
    output logic [NUM_PORTS-1:0]          err_o,
    output logic [DATA_W-1:0]             rdata_o,
    output logic                          mem_req_o,
    output logic                          mem_we_o,
    output logic [DATA_W/8-1:0]           mem_be_o,
    output logic [ADDR_W-1:0]             mem_addr_o,
    output logic [DATA_W-1:0]             mem_wdata_o,
    input  logic                          mem_rvalid_i,
    input  logic [DATA_W-1:0]             mem_rdata_i,
    output logic                          proto_err_o,
    output logic [31:0]                   grant_cnt_o
);

    localparam int BE_W  = DATA_W / 8;
    localparam int PID_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam logic [ADDR_W-1:0] WIN_MASK = ~(ADDR_W'(MEM_SIZE - 1));

    typedef struct packed {
        logic             vld;
        logic [PID_W-1:0] pid;
        logic             err;
    } tag_t;

    logic [PID_W-1:0]  rr_ptr_q;
    logic              win_vld;
    logic [PID_W-1:0]  win_idx;
    logic              grant_vld;
    logic              in_win;
    logic [ADDR_W-1:0] win_addr;
    tag_t              push_tag;
    tag_t              fin_tag;
    tag_t              pipe_q [RD_LATENCY];
    logic [NUM_PORTS-1:0] rvalid_d, rvalid_q;
    logic [NUM_PORTS-1:0] err_d, err_q;
    logic [DATA_W-1:0]    rdata_d, rdata_q;
    logic                 proto_d, proto_q;
    logic [31:0]          cnt_q;
    int                   start;
    int                   cand;

    // Pick the winner: fixed mode scans from port 0, round-robin scans from the port after the last winner.
    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        cand    = 0;
        start   = (ARB_MODE == 1) ? int'(rr_ptr_q) + 1 : 0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            cand = start + k;
            if (cand >= NUM_PORTS) cand = cand - NUM_PORTS;
            if (!win_vld && req_i[cand[PID_W-1:0]]) begin
                win_vld = 1'b1;
                win_idx = cand[PID_W-1:0];
            end
        end
    end

    // Grant, window check and RAM-side mux; out-of-window winners are granted but never reach the RAM.
    always_comb begin
        grant_vld   = win_vld & ~rst_i;
        win_addr    = addr_i[win_idx*ADDR_W +: ADDR_W];
        in_win      = (win_addr & WIN_MASK) == MEM_START;
        gnt_o       = grant_vld ? (NUM_PORTS'(1) << win_idx) : '0;
        mem_req_o   = grant_vld & in_win;
        mem_we_o    = grant_vld & in_win & we_i[win_idx];
        mem_be_o    = (grant_vld & in_win) ? be_i[win_idx*BE_W +: BE_W] : '0;
        mem_addr_o  = grant_vld ? win_addr : '0;
        mem_wdata_o = grant_vld ? wdata_i[win_idx*DATA_W +: DATA_W] : '0;
        push_tag.vld = grant_vld;
        push_tag.pid = win_idx;
        push_tag.err = ~in_win;
    end

    // Tag shift register; its last stage lines up with the RAM's rvalid for the same access.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < RD_LATENCY; i++) pipe_q[i] <= '0;
        end else begin
            pipe_q[0] <= push_tag;
            for (int i = 1; i < RD_LATENCY; i++) pipe_q[i] <= pipe_q[i-1];
        end
    end

    // Build the one-cycle response and detect a missing or unexpected RAM rvalid.
    always_comb begin
        fin_tag  = pipe_q[RD_LATENCY-1];
        rvalid_d = fin_tag.vld ? (NUM_PORTS'(1) << fin_tag.pid) : '0;
        err_d    = (fin_tag.vld && fin_tag.err) ? (NUM_PORTS'(1) << fin_tag.pid) : '0;
        rdata_d  = (fin_tag.vld && !fin_tag.err) ? mem_rdata_i : '0;
        proto_d  = proto_q | ((fin_tag.vld & ~fin_tag.err) ^ mem_rvalid_i);
    end

    // Response registers, sticky protocol flag, RR pointer and grant counter.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rvalid_q <= '0;
            err_q    <= '0;
            rdata_q  <= '0;
            proto_q  <= 1'b0;
            rr_ptr_q <= PID_W'(NUM_PORTS - 1);
            cnt_q    <= '0;
        end else begin
            rvalid_q <= rvalid_d;
            err_q    <= err_d;
            rdata_q  <= rdata_d;
            proto_q  <= proto_d;
            if (grant_vld) begin
                rr_ptr_q <= win_idx;
                cnt_q    <= cnt_q + 32'd1;
            end
        end
    end

    assign rvalid_o    = rvalid_q;
    assign err_o       = err_q;
    assign rdata_o     = rdata_q;
    assign proto_err_o = proto_q;
    assign grant_cnt_o = cnt_q;

endmodule

// File: tb/tb_obi_mem_arbiter.sv
// Purpose: directed checks of two arbiter instances (2-port fixed/latency 1, 3-port round-robin/latency 3).
// Latency: expectations are cycle-exact relative to the grant cycle.
// Backpressure: bench RAM models always answer unless told to drop or inject an rvalid.
module tb_obi_mem_arbiter;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // Fixed-priority instance, 2 ports, RD_LATENCY=1
    logic [1:0]  f_req, f_gnt, f_we, f_rvalid, f_err;
    logic [7:0]  f_be;
    logic [63:0] f_addr, f_wdata;
    logic [31:0] f_rdata, f_mem_addr, f_mem_wdata, f_mem_rdata, f_cnt;
    logic        f_mem_req, f_mem_we, f_mem_rvalid, f_proto, f_spur;
    logic [3:0]  f_mem_be;

    // Round-robin instance, 3 ports, RD_LATENCY=3
    logic [2:0]  r_req, r_gnt, r_we, r_rvalid, r_err;
    logic [11:0] r_be;
    logic [95:0] r_addr, r_wdata;
    logic [31:0] r_rdata, r_mem_addr, r_mem_wdata, r_mem_rdata, r_cnt;
    logic        r_mem_req, r_mem_we, r_mem_rvalid, r_proto, r_drop;
    logic [3:0]  r_mem_be;

    obi_mem_arbiter #(.NUM_PORTS(2), .ARB_MODE(0), .RD_LATENCY(1)) u_fix (
        .clk_i(clk), .rst_i(rst), .req_i(f_req), .gnt_o(f_gnt), .we_i(f_we), .be_i(f_be),
        .addr_i(f_addr), .wdata_i(f_wdata), .rvalid_o(f_rvalid), .err_o(f_err), .rdata_o(f_rdata),
        .mem_req_o(f_mem_req), .mem_we_o(f_mem_we), .mem_be_o(f_mem_be), .mem_addr_o(f_mem_addr),
        .mem_wdata_o(f_mem_wdata), .mem_rvalid_i(f_mem_rvalid), .mem_rdata_i(f_mem_rdata),
        .proto_err_o(f_proto), .grant_cnt_o(f_cnt)
    );

    obi_mem_arbiter #(.NUM_PORTS(3), .ARB_MODE(1), .RD_LATENCY(3)) u_rr (
        .clk_i(clk), .rst_i(rst), .req_i(r_req), .gnt_o(r_gnt), .we_i(r_we), .be_i(r_be),
        .addr_i(r_addr), .wdata_i(r_wdata), .rvalid_o(r_rvalid), .err_o(r_err), .rdata_o(r_rdata),
        .mem_req_o(r_mem_req), .mem_we_o(r_mem_we), .mem_be_o(r_mem_be), .mem_addr_o(r_mem_addr),
        .mem_wdata_o(r_mem_wdata), .mem_rvalid_i(r_mem_rvalid), .mem_rdata_i(r_mem_rdata),
        .proto_err_o(r_proto), .grant_cnt_o(r_cnt)
    );

    // RAM model for the fixed instance: 1-cycle latency, byte-enabled writes, known words set on reset.
    logic [31:0] ram_a [0:1023];
    logic        a_rv;
    logic [31:0] a_rd;
    always_ff @(posedge clk) begin
        a_rv <= f_mem_req;
        a_rd <= 32'h0;
        if (rst) begin
            ram_a[16]  <= 32'h0000_0000;
            ram_a[64]  <= 32'h1111_0100;
            ram_a[128] <= 32'h2222_0200;
        end else if (f_mem_req) begin
            if (f_mem_we) begin
                for (int b = 0; b < 4; b++)
                    if (f_mem_be[b]) ram_a[f_mem_addr[11:2]][8*b +: 8] <= f_mem_wdata[8*b +: 8];
            end else begin
                a_rd <= ram_a[f_mem_addr[11:2]];
            end
        end
    end
    assign f_mem_rvalid = a_rv | f_spur;
    assign f_mem_rdata  = a_rd;

    // RAM model for the RR instance: 3-cycle latency, data derived from address, optional dropped rvalid.
    logic [2:0]  b_rv;
    logic [31:0] b_rd0, b_rd1, b_rd2;
    always_ff @(posedge clk) begin
        b_rv  <= {b_rv[1:0], r_mem_req & ~r_drop};
        b_rd0 <= {r_mem_addr[15:0], 16'hC0DE};
        b_rd1 <= b_rd0;
        b_rd2 <= b_rd1;
    end
    assign r_mem_rvalid = b_rv[2];
    assign r_mem_rdata  = b_rd2;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Advance to the drive point of the next cycle.
    task automatic nxt();
        @(posedge clk);
        #2;
    endtask

    int p;

    initial begin
        rst = 1'b1;
        f_req = 2'b11; f_we = '0; f_be = 8'hFF; f_addr = {32'h200, 32'h100}; f_wdata = '0; f_spur = 1'b0;
        r_req = 3'b111; r_we = '0; r_be = 12'hFFF; r_addr = {32'h1008, 32'h1004, 32'h1000}; r_wdata = '0;
        r_drop = 1'b0;
        b_rv = '0;

        // Reset: requests present, yet nothing is granted
        repeat (3) nxt();
        #1;
        chk("rst_gnt", f_gnt, 0);
        chk("rst_mreq", f_mem_req, 0);
        chk("rst_rvalid", f_rvalid, 0);
        chk("rst_err", f_err, 0);
        chk("rst_rdata", f_rdata, 0);
        chk("rst_proto", f_proto, 0);
        chk("rst_cnt", f_cnt, 0);
        chk("rst_rr_gnt", r_gnt, 0);

        // Fixed priority: both ports read in the same cycle
        nxt(); rst = 1'b0; r_req = 3'b000; #1;
        chk("fix_gnt0", f_gnt, 2'b01);
        chk("fix_maddr0", f_mem_addr, 32'h100);
        chk("fix_mreq0", f_mem_req, 1);
        nxt(); f_req = 2'b10; #1;
        chk("fix_gnt1", f_gnt, 2'b10);
        chk("fix_maddr1", f_mem_addr, 32'h200);
        chk("fix_cnt1", f_cnt, 1);
        nxt(); f_req = 2'b00; #1;
        chk("idle_gnt", f_gnt, 0);
        chk("idle_maddr", f_mem_addr, 0);
        chk("fix_rv0", f_rvalid, 2'b01);
        chk("fix_rd0", f_rdata, 32'h1111_0100);
        chk("fix_err0", f_err, 0);
        nxt(); #1;
        chk("fix_rv1", f_rvalid, 2'b10);
        chk("fix_rd1", f_rdata, 32'h2222_0200);
        chk("fix_cnt2", f_cnt, 2);
        nxt(); #1;
        chk("fix_rv_done", f_rvalid, 0);

        // Partial write then read-back on port 1
        nxt(); f_req = 2'b10; f_we = 2'b10; f_be[7:4] = 4'b0011; f_addr[63:32] = 32'h40;
        f_wdata[63:32] = 32'hDEAD_BEEF; #1;
        chk("wr_gnt", f_gnt, 2'b10);
        chk("wr_mwe", f_mem_we, 1);
        chk("wr_mbe", f_mem_be, 4'b0011);
        chk("wr_mwdata", f_mem_wdata, 32'hDEAD_BEEF);
        nxt(); f_we = 2'b00; #1;
        chk("rd_gnt", f_gnt, 2'b10);
        chk("rd_mwe", f_mem_we, 0);
        nxt(); f_req = 2'b00; #1;
        chk("wr_rv", f_rvalid, 2'b10);
        chk("wr_err", f_err, 0);
        nxt(); #1;
        chk("rd_rv", f_rvalid, 2'b10);
        chk("rd_data", f_rdata, 32'h0000_BEEF);

        // Out-of-window access: granted, never issued, error response with zero data
        nxt(); f_req = 2'b01; f_we = 2'b01; f_be[3:0] = 4'hF; f_addr[31:0] = 32'h0001_0000; #1;
        chk("oow_gnt", f_gnt, 2'b01);
        chk("oow_mreq", f_mem_req, 0);
        chk("oow_mwe", f_mem_we, 0);
        chk("oow_mbe", f_mem_be, 0);
        nxt(); f_req = 2'b00; f_we = 2'b00; #1;
        nxt(); #1;
        chk("oow_rv", f_rvalid, 2'b01);
        chk("oow_err", f_err, 2'b01);
        chk("oow_rdata", f_rdata, 0);
        chk("oow_proto", f_proto, 0);
        chk("oow_cnt", f_cnt, 5);

        // Round-robin: all three ports request for 6 cycles
        for (int k = 0; k < 10; k++) begin
            nxt(); r_req = (k < 6) ? 3'b111 : 3'b000; #1;
            chk("rr_gnt", r_gnt, (k < 6) ? (3'b001 << (k % 3)) : 3'b000);
            if (k >= 4) begin
                p = (k - 4) % 3;
                chk("rr_rv", r_rvalid, 3'b001 << p);
                chk("rr_rdata", r_rdata, {16'h1000 + 16'(4 * p), 16'hC0DE});
            end else begin
                chk("rr_rv_early", r_rvalid, 0);
            end
            if (k == 6) chk("rr_cnt", r_cnt, 6);
        end
        chk("rr_proto_ok", r_proto, 0);

        // RAM drops one rvalid: flag rises after the expected response cycle and sticks
        nxt(); r_req = 3'b100; r_drop = 1'b1; #1;
        chk("drop_gnt", r_gnt, 3'b100);
        nxt(); r_req = 3'b000; r_drop = 1'b0;
        nxt();
        nxt(); #1;
        chk("drop_proto_pre", r_proto, 0);
        nxt(); #1;
        chk("drop_proto", r_proto, 1);
        chk("drop_rv", r_rvalid, 3'b100);
        nxt(); nxt(); #1;
        chk("drop_proto_sticky", r_proto, 1);

        // Spurious RAM rvalid with nothing in flight
        nxt(); f_spur = 1'b1;
        nxt(); f_spur = 1'b0; #1;
        chk("spur_proto", f_proto, 1);

        // Reset one cycle after a grant drops the in-flight response
        nxt(); f_req = 2'b01; f_addr = {32'h200, 32'h100}; #1;
        chk("mid_gnt", f_gnt, 2'b01);
        nxt(); f_req = 2'b00; rst = 1'b1;
        nxt(); rst = 1'b0; f_req = 2'b11; r_req = 3'b111; #1;
        chk("mid_rv", f_rvalid, 0);
        chk("mid_cnt", f_cnt, 0);
        chk("mid_proto", f_proto, 0);
        chk("mid_rr_proto", r_proto, 0);
        chk("mid_rr_cnt", r_cnt, 0);
        chk("mid_gnt_after", f_gnt, 2'b01);
        chk("mid_rr_gnt_after", r_gnt, 3'b001);
        nxt(); f_req = 2'b00; r_req = 3'b000; #1;
        chk("mid_rv_none", f_rvalid, 0);
        nxt(); #1;
        chk("mid_rv_new", f_rvalid, 2'b01);
        chk("mid_rd_new", f_rdata, 32'h1111_0100);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
